// File: rtl/can_tx_mailbox_scheduler.sv
// Multi-mailbox transmit scheduler feeding CAN_CONTROLLER: lowest-address arbitration, start timeout/retry.
// Optional feature: define RETRY_LIMIT_EN to abort a frame after MAX_RETRY consecutive start timeouts.
module can_tx_mailbox_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int CNT_W     = 4,
  parameter int START_TO  = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                        CLOCK_SIGNAL_IN,
  input  logic                        RESET,
  input  logic [NUM_MB-1:0]           mb_load,
  input  logic [NUM_MB-1:0]           mb_cancel,
  input  logic [NUM_MB*ADDR_W-1:0]    mb_addr,
  input  logic [NUM_MB*DATA_W-1:0]    mb_data,
  input  logic [NUM_MB*CNT_W-1:0]     mb_cnt,
  output logic [NUM_MB-1:0]           mb_pending,
  output logic [ADDR_W-1:0]           can_addr,
  output logic [DATA_W-1:0]           transmit_data,
  output logic [CNT_W-1:0]            transmit_data_counter,
  output logic                        send_data,
  input  logic                        txing,
  output logic                        tx_done,
  output logic                        tx_abort,
  output logic [$clog2(NUM_MB)-1:0]   tx_idx
);

  localparam int IDX_W = $clog2(NUM_MB);
  localparam int TO_W  = $clog2(START_TO + 1);
  localparam int RC_W  = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_START   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_r, state_n_s;
  logic [ADDR_W-1:0]   addr_r [NUM_MB];
  logic [DATA_W-1:0]   data_r [NUM_MB];
  logic [CNT_W-1:0]    cnt_r  [NUM_MB];
  logic [NUM_MB-1:0]   pending_r;
  logic [IDX_W-1:0]    tx_idx_r;
  logic [ADDR_W-1:0]   can_addr_r;
  logic [DATA_W-1:0]   tdata_r;
  logic [CNT_W-1:0]    tcnt_r;
  logic                send_data_r;
  logic                tx_done_r;
  logic                tx_abort_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic [RC_W-1:0]     retry_r;

  logic [IDX_W-1:0]    win_idx_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic                win_found_s;
  logic                take_s;
  logic [NUM_MB-1:0]   inflight_s;
  logic                timeout_s;
  logic                done_s;
  logic                abort_s;

  // Arbitration: lowest address wins; strict compare keeps the lowest index on ties
  always_comb begin
    win_idx_s   = '0;
    win_addr_s  = '1;
    win_found_s = 1'b0;
    take_s      = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      take_s      = pending_r[i] && (!win_found_s || (addr_r[i] < win_addr_s));
      win_idx_s   = take_s ? IDX_W'(i) : win_idx_s;
      win_addr_s  = take_s ? addr_r[i] : win_addr_s;
      win_found_s = win_found_s | take_s;
    end
  end

  // Mailbox currently owned by the FSM (cancel is ignored for it)
  always_comb begin
    inflight_s = '0;
    case (state_r)
      S_SELECT:           inflight_s[win_idx_s] = 1'b1;
      S_START, S_WAIT_TX: inflight_s[tx_idx_r]  = 1'b1;
      default:            inflight_s = '0;
    endcase
  end

  assign timeout_s = (state_r == S_START) && !txing && (to_cnt_r >= TO_W'(START_TO - 1));
  assign done_s    = (state_r == S_WAIT_TX) && !txing;
`ifdef RETRY_LIMIT_EN
  assign abort_s   = timeout_s && (retry_r >= RC_W'(MAX_RETRY - 1));
`else
  assign abort_s   = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE: begin
        if ((|pending_r) && !txing) begin
          state_n_s = S_SELECT;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_SELECT: begin
        // a cancel in the same cycle as IDLE->SELECT can leave nothing to send
        if (win_found_s) begin
          state_n_s = S_START;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_START: begin
        if (txing) begin
          state_n_s = S_WAIT_TX;
        end else if (timeout_s) begin
          state_n_s = S_IDLE;
        end else begin
          state_n_s = S_START;
        end
      end
      S_WAIT_TX: begin
        if (!txing) begin
          state_n_s = S_DONE;
        end else begin
          state_n_s = S_WAIT_TX;
        end
      end
      S_DONE:  state_n_s = S_IDLE;
      default: state_n_s = S_IDLE;
    endcase
  end

  // FSM state, controller-facing outputs, timeout and retry counters
  always_ff @(posedge CLOCK_SIGNAL_IN) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      send_data_r <= 1'b0;
      tx_done_r   <= 1'b0;
      tx_abort_r  <= 1'b0;
      tx_idx_r    <= '0;
      can_addr_r  <= '0;
      tdata_r     <= '0;
      tcnt_r      <= '0;
      to_cnt_r    <= '0;
      retry_r     <= '0;
    end else begin
      state_r     <= state_n_s;
      send_data_r <= (state_n_s == S_START);
      tx_done_r   <= done_s;
      tx_abort_r  <= abort_s;
      if ((state_r == S_SELECT) && win_found_s) begin
        tx_idx_r   <= win_idx_s;
        can_addr_r <= addr_r[win_idx_s];
        tdata_r    <= data_r[win_idx_s];
        tcnt_r     <= cnt_r[win_idx_s];
        if (win_idx_s != tx_idx_r) begin
          retry_r <= '0;
        end
      end
      if (state_r != S_START) begin
        to_cnt_r <= '0;
      end else if (to_cnt_r < TO_W'(START_TO)) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
      if (done_s || abort_s) begin
        retry_r <= '0;
      end else if (timeout_s && (retry_r < RC_W'(MAX_RETRY))) begin
        retry_r <= retry_r + RC_W'(1);
      end
    end
  end

  // Mailbox storage: retire/abort first, then load (wins over cancel), then cancel
  always_ff @(posedge CLOCK_SIGNAL_IN) begin
    for (int i = 0; i < NUM_MB; i++) begin
      if (RESET) begin
        pending_r[i] <= 1'b0;
        addr_r[i]    <= '0;
        data_r[i]    <= '0;
        cnt_r[i]     <= '0;
      end else if ((done_s || abort_s) && (tx_idx_r == IDX_W'(i))) begin
        pending_r[i] <= 1'b0;
      end else if (mb_load[i] && !pending_r[i]) begin
        pending_r[i] <= 1'b1;
        addr_r[i]    <= mb_addr[i*ADDR_W +: ADDR_W];
        data_r[i]    <= mb_data[i*DATA_W +: DATA_W];
        cnt_r[i]     <= mb_cnt[i*CNT_W +: CNT_W];
      end else if (mb_cancel[i] && !inflight_s[i]) begin
        pending_r[i] <= 1'b0;
      end
    end
  end

  assign mb_pending            = pending_r;
  assign can_addr              = can_addr_r;
  assign transmit_data         = tdata_r;
  assign transmit_data_counter = tcnt_r;
  assign send_data             = send_data_r;
  assign tx_done               = tx_done_r;
  assign tx_abort              = tx_abort_r;
  assign tx_idx                = tx_idx_r;

endmodule

// File: tb/tb_can_tx_mailbox_scheduler.sv
// Scoreboard bench for can_tx_mailbox_scheduler: expected frames queued at load, checked at send.
module tb_can_tx_mailbox_scheduler;

  localparam int NUM_MB   = 4;
  localparam int START_TO = 64;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  mb_load, mb_cancel;
  logic [15:0] mb_addr, mb_data, mb_cnt;
  logic [3:0]  mb_pending;
  logic [3:0]  can_addr, transmit_data, transmit_data_counter;
  logic        send_data, txing, tx_done, tx_abort;
  logic [1:0]  tx_idx;

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] c;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int errors = 0;

  can_tx_mailbox_scheduler #(.NUM_MB(NUM_MB), .START_TO(START_TO)) dut (
    .CLOCK_SIGNAL_IN(clk), .RESET(RESET),
    .mb_load(mb_load), .mb_cancel(mb_cancel),
    .mb_addr(mb_addr), .mb_data(mb_data), .mb_cnt(mb_cnt),
    .mb_pending(mb_pending), .can_addr(can_addr), .transmit_data(transmit_data),
    .transmit_data_counter(transmit_data_counter), .send_data(send_data),
    .txing(txing), .tx_done(tx_done), .tx_abort(tx_abort), .tx_idx(tx_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mb(input int i, input logic [3:0] a, input logic [3:0] d, input logic [3:0] c);
    mb_load[i] = 1'b1;
    mb_addr[i*4 +: 4] = a;
    mb_data[i*4 +: 4] = d;
    mb_cnt[i*4 +: 4]  = c;
  endtask

  task automatic wait_send(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (send_data === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL send_start: send_data=%b required 1 within 300 cycles", send_data);
    end
  endtask

  // controller model: accept the frame, keep TXING high for hold cycles, then check retirement
  task automatic serve_frame(input int hold);
    frame_t e;
    bit seen;
    wait_send(seen);
    if (!seen) return;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: unexpected frame idx=%0d addr=%0d", tx_idx, can_addr);
      return;
    end
    e = sb.pop_front();
    if (tx_idx !== 2'(e.idx) || can_addr !== e.a || transmit_data !== e.d || transmit_data_counter !== e.c) begin
      errors++;
      $display("FAIL frame: got idx=%0d a=%0d d=%0d c=%0d required idx=%0d a=%0d d=%0d c=%0d",
               tx_idx, can_addr, transmit_data, transmit_data_counter, e.idx, e.a, e.d, e.c);
    end
    txing = 1'b1;
    tick();
    checks++;
    if (send_data !== 1'b0) begin
      errors++;
      $display("FAIL send_drop: send_data=%b required 0", send_data);
    end
    repeat (hold - 1) tick();
    txing = 1'b0;
    tick();
    checks++;
    if (tx_done !== 1'b1 || tx_idx !== 2'(e.idx) || mb_pending[e.idx] !== 1'b0) begin
      errors++;
      $display("FAIL done: tx_done=%b idx=%0d pending=%b required 1 idx=%0d pending bit 0",
               tx_done, tx_idx, mb_pending, e.idx);
    end
    tick();
    checks++;
    if (tx_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: tx_done=%b required 0", tx_done);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    checks++;
    if (mb_pending !== 4'b0000 || send_data !== 1'b0 || tx_done !== 1'b0 || tx_abort !== 1'b0 ||
        tx_idx !== 2'd0 || can_addr !== 4'd0 || transmit_data !== 4'd0 || transmit_data_counter !== 4'd0) begin
      errors++;
      $display("FAIL reset: pend=%b sd=%b done=%b abort=%b idx=%0d a=%0d d=%0d c=%0d required all 0",
               mb_pending, send_data, tx_done, tx_abort, tx_idx, can_addr, transmit_data, transmit_data_counter);
    end
    RESET = 1'b0;
  endtask

  task automatic test_single();
    set_mb(0, 4'd5, 4'd3, 4'd2);
    sb.push_back('{0, 4'd5, 4'd3, 4'd2});
    tick();
    mb_load = '0;
    checks++;
    if (mb_pending !== 4'b0001 || send_data !== 1'b0) begin
      errors++;
      $display("FAIL lat_pending: pend=%b sd=%b required 0001 0", mb_pending, send_data);
    end
    tick();
    checks++;
    if (send_data !== 1'b0) begin
      errors++;
      $display("FAIL lat_select: send_data=%b required 0", send_data);
    end
    tick();
    checks++;
    if (send_data !== 1'b1) begin
      errors++;
      $display("FAIL lat_start: send_data=%b required 1", send_data);
    end
    serve_frame(4);
  endtask

  task automatic test_arbitration();
    logic [3:0] ma [3];
    bit used [3];
    int best;
    ma[0] = 4'd9; ma[1] = 4'd2; ma[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      set_mb(i, ma[i], 4'(i + 1), 4'(i + 4));
      used[i] = 1'b0;
    end
    // expected order: lowest address, then lowest index
    for (int n = 0; n < 3; n++) begin
      best = -1;
      for (int i = 0; i < 3; i++) begin
        if (!used[i] && (best < 0 || ma[i] < ma[best])) best = i;
      end
      used[best] = 1'b1;
      sb.push_back('{best, ma[best], 4'(best + 1), 4'(best + 4)});
    end
    tick();
    mb_load = '0;
    repeat (3) serve_frame(3);
  endtask

  task automatic test_timeout();
    bit seen;
    int cnt;
    set_mb(0, 4'd1, 4'd6, 4'd1);
    sb.push_back('{0, 4'd1, 4'd6, 4'd1});
    tick();
    mb_load = '0;
`ifdef RETRY_LIMIT_EN
    for (int r = 0; r < 3; r++) begin
`else
    for (int r = 0; r < 1; r++) begin
`endif
      wait_send(seen);
      cnt = 0;
      while (send_data === 1'b1 && cnt < 200) begin
        cnt++;
        tick();
      end
      checks++;
      if (cnt != START_TO) begin
        errors++;
        $display("FAIL timeout_len: send_data high %0d cycles required %0d", cnt, START_TO);
      end
    end
`ifdef RETRY_LIMIT_EN
    checks++;
    if (tx_abort !== 1'b1 || mb_pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort: tx_abort=%b pend=%b required 1 and bit0 0", tx_abort, mb_pending);
    end
    void'(sb.pop_front());
`else
    checks++;
    if (tx_abort !== 1'b0 || mb_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL retry_keep: tx_abort=%b pend=%b required 0 and bit0 1", tx_abort, mb_pending);
    end
    serve_frame(2);
`endif
  endtask

  task automatic test_cancel();
    bit seen;
    bit leaked;
    set_mb(0, 4'd3, 4'd8, 4'd2);
    set_mb(1, 4'd4, 4'd9, 4'd3);
    sb.push_back('{0, 4'd3, 4'd8, 4'd2});
    tick();
    mb_load = '0;
    wait_send(seen);
    if (seen) begin
      void'(sb.pop_front());
      txing = 1'b1;
      tick();
      mb_cancel = 4'b0011;
      tick();
      mb_cancel = '0;
      checks++;
      if (mb_pending !== 4'b0001) begin
        errors++;
        $display("FAIL cancel: pend=%b required 0001", mb_pending);
      end
      txing = 1'b0;
      tick();
      checks++;
      if (tx_done !== 1'b1 || tx_idx !== 2'd0 || mb_pending !== 4'b0000) begin
        errors++;
        $display("FAIL cancel_done: done=%b idx=%0d pend=%b required 1 0 0000", tx_done, tx_idx, mb_pending);
      end
      leaked = 1'b0;
      repeat (20) begin
        tick();
        if (send_data === 1'b1) leaked = 1'b1;
      end
      checks++;
      if (leaked) begin
        errors++;
        $display("FAIL cancel_leak: send_data rose=%b required 0", leaked);
      end
    end
  endtask

  task automatic test_no_overwrite();
    set_mb(0, 4'd6, 4'd3, 4'd1);
    sb.push_back('{0, 4'd6, 4'd3, 4'd1});
    tick();
    set_mb(0, 4'd6, 4'd7, 4'd5);
    tick();
    mb_load = '0;
    serve_frame(2);
  endtask

  task automatic test_reset_midframe();
    bit seen;
    bit spurious;
    set_mb(0, 4'd1, 4'd2, 4'd3);
    set_mb(2, 4'd5, 4'd4, 4'd1);
    tick();
    mb_load = '0;
    wait_send(seen);
    txing = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    checks++;
    if (send_data !== 1'b0 || mb_pending !== 4'b0000 || tx_done !== 1'b0 || tx_idx !== 2'd0 || can_addr !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: sd=%b pend=%b done=%b idx=%0d a=%0d required 0 0000 0 0 0",
               send_data, mb_pending, tx_done, tx_idx, can_addr);
    end
    RESET = 1'b0;
    tick();
    txing = 1'b0;
    spurious = 1'b0;
    repeat (10) begin
      tick();
      if (tx_done === 1'b1 || send_data === 1'b1) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL mid_reset_quiet: activity=%b required 0", spurious);
    end
  endtask

  initial begin
    RESET = 1'b1;
    mb_load = '0;
    mb_cancel = '0;
    mb_addr = '0;
    mb_data = '0;
    mb_cnt = '0;
    txing = 1'b0;
    test_reset();
    test_single();
    test_arbitration();
    test_timeout();
    test_cancel();
    test_no_overwrite();
    test_reset_midframe();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d frames unsent required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
